// File: rtl/tie_cosim_pkg.sv
// ---------------------------------------------------------------------------
// tie_cosim_pkg
//   Shared constants and types for the TIE change-capture queue.
//   - TIE_WIDTH / TIE_DEPTH / TIE_TS_WIDTH : default parameter values
//   - tie_entry_t : one queue entry (changed word + capture timestamp) at the
//                   default widths
//   - entry_bits() : width of the stored entry, with or without a timestamp
// ---------------------------------------------------------------------------
package tie_cosim_pkg;

  localparam int TIE_WIDTH    = 50;
  localparam int TIE_DEPTH    = 8;
  localparam int TIE_TS_WIDTH = 16;

  // "time" is a reserved word, so the timestamp field is called stamp.
  typedef struct packed {
    logic [TIE_WIDTH-1:0]    data;
    logic [TIE_TS_WIDTH-1:0] stamp;
  } tie_entry_t;

  function automatic int entry_bits(input int data_w, input int ts_w, input bit ts_en);
    return ts_en ? (data_w + ts_w) : data_w;
  endfunction

endpackage

// File: rtl/tie_sync_fifo.sv
// ---------------------------------------------------------------------------
// tie_sync_fifo
//   Single-clock FIFO storage with wrap-around pointers carrying an extra MSB
//   to tell full from empty.  The head is presented combinationally; while
//   the queue is empty the head shows the most recently popped entry
//   (zero after reset).
//
//   Ports
//     clk    : clock, rising edge
//     reset  : synchronous, active-high; flushes all entries
//     push   : write wdata at the tail (accepted if not full, or if a pop
//              happens in the same cycle)
//     pop    : remove the head (ignored while empty)
//     wdata  : entry to write
//     rdata  : head entry, or last popped entry while empty
//     count  : occupancy, 0..DEPTH
//     full   : count == DEPTH
//     empty  : count == 0
// ---------------------------------------------------------------------------
module tie_sync_fifo #(
  parameter int EW    = 66,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [EW-1:0]          wdata,
  output logic [EW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] last;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          pop_ok;
  logic          wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign pop_ok = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign wr_ok  = push && (!full || pop_ok);

  assign rdata = empty ? last : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        last   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage is not reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/tie_change_fifo.sv
// ---------------------------------------------------------------------------
// tie_change_fifo
//   Watches the exported TIE state word every cycle and queues each new value
//   that differs from the previous cycle's value.  A consumer drains the queue
//   with a valid/ready handshake.  Changes arriving while the queue is full
//   (and nothing is popped that cycle) are dropped and flagged on a sticky
//   Overflow bit.
//
//   Build option: define TIE_CHANGE_TIMESTAMP_EN to add a free-running
//   TS_WIDTH timestamp counter whose value is stored with every entry and
//   presented on ChgTime.  Without it, no counter or timestamp storage exists
//   and ChgTime is tied to zero.
//
//   Ports
//     CLK         : clock, rising edge
//     Reset       : synchronous, active-high
//     TIE_control : monitored state word
//     ChgData     : head-of-queue word (last popped word while empty)
//     ChgTime     : head-of-queue timestamp (0 without the timestamp build)
//     ChgValid    : queue holds at least one entry
//     ChgReady    : consumer takes the head entry this cycle
//     Overflow    : sticky, a change was dropped
//     OvfClr      : clears Overflow, wins over a same-cycle set
//     Count       : queue occupancy
// ---------------------------------------------------------------------------
module tie_change_fifo
  import tie_cosim_pkg::*;
#(
  parameter int WIDTH    = TIE_WIDTH,
  parameter int DEPTH    = TIE_DEPTH,
  parameter int TS_WIDTH = TIE_TS_WIDTH
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [WIDTH-1:0]       TIE_control,
  output logic [WIDTH-1:0]       ChgData,
  output logic [TS_WIDTH-1:0]    ChgTime,
  output logic                   ChgValid,
  input  logic                   ChgReady,
  output logic                   Overflow,
  input  logic                   OvfClr,
  output logic [$clog2(DEPTH):0] Count
);

`ifdef TIE_CHANGE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int EW = entry_bits(WIDTH, TS_WIDTH, TS_EN);

  logic [WIDTH-1:0] prev;
  logic             push;
  logic             pop_req;
  logic             full;
  logic             empty;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    rdata;

  // prev resets to zero, so a nonzero word on the first cycle out of reset
  // counts as a change.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      prev <= '0;
    end else begin
      prev <= TIE_control;
    end
  end

  assign push    = (TIE_control != prev);
  assign pop_req = ChgReady && !empty;

`ifdef TIE_CHANGE_TIMESTAMP_EN
  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;
  logic [TS_WIDTH-1:0] tstamp;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      tstamp <= '0;
    end else begin
      tstamp <= tstamp + TS_ONE;
    end
  end

  assign wdata   = {TIE_control, tstamp};
  assign ChgData = rdata[EW-1 -: WIDTH];
  assign ChgTime = rdata[TS_WIDTH-1:0];
`else
  assign wdata   = TIE_control;
  assign ChgData = rdata;
  assign ChgTime = '0;
`endif

  tie_sync_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (Reset),
    .push  (push),
    .pop   (pop_req),
    .wdata (wdata),
    .rdata (rdata),
    .count (Count),
    .full  (full),
    .empty (empty)
  );

  assign ChgValid = !empty;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (OvfClr) begin
      Overflow <= 1'b0;
    end else if (push && full && !pop_req) begin
      Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tie_change_fifo.sv
module tb_tie_change_fifo;

  localparam int W   = 50;
  localparam int D   = 8;
  localparam int TSW = 16;

`ifdef TIE_CHANGE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic           rst;
  logic [W-1:0]   tie;
  logic           ready;
  logic           ovfclr;
  logic [W-1:0]   chg_data;
  logic [TSW-1:0] chg_time;
  logic           chg_valid;
  logic           overflow;
  logic [3:0]     count;

  // small instance for timestamp wrap
  logic       rst4;
  logic [7:0] tie4;
  logic       ready4;
  logic       ovfclr4;
  logic [7:0] data4;
  logic [3:0] time4;
  logic       valid4;
  logic       ovf4;
  logic [2:0] count4;

  tie_change_fifo #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TSW)) u_dut (
    .CLK(clk), .Reset(rst), .TIE_control(tie), .ChgData(chg_data), .ChgTime(chg_time),
    .ChgValid(chg_valid), .ChgReady(ready), .Overflow(overflow), .OvfClr(ovfclr), .Count(count)
  );

  tie_change_fifo #(.WIDTH(8), .DEPTH(4), .TS_WIDTH(4)) u_ts4 (
    .CLK(clk), .Reset(rst4), .TIE_control(tie4), .ChgData(data4), .ChgTime(time4),
    .ChgValid(valid4), .ChgReady(ready4), .Overflow(ovf4), .OvfClr(ovfclr4), .Count(count4)
  );

  // reference model: a queue of (word, capture cycle) pairs
  typedef struct {
    logic [W-1:0]   d;
    logic [TSW-1:0] t;
  } ent_t;

  ent_t           q[$];
  logic [W-1:0]   m_prev   = '0;
  logic [W-1:0]   m_last_d = '0;
  logic [TSW-1:0] m_last_t = '0;
  logic [TSW-1:0] m_ts     = '0;
  bit             m_ovf    = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit   push;
    bit   pop;
    bit   room;
    ent_t e;
    if (rst) begin
      q.delete();
      m_prev   = '0;
      m_last_d = '0;
      m_last_t = '0;
      m_ts     = '0;
      m_ovf    = 1'b0;
    end else begin
      push = (tie != m_prev);
      pop  = (q.size() > 0) && ready;
      room = (q.size() < D);
      if (pop) begin
        e        = q.pop_front();
        m_last_d = e.d;
        m_last_t = e.t;
      end
      if (push) begin
        if (room || pop) q.push_back('{d: tie, t: m_ts});
        else             m_ovf = 1'b1;
      end
      if (ovfclr) m_ovf = 1'b0;
      m_prev = tie;
      m_ts   = m_ts + 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit             v;
    logic [W-1:0]   ed;
    logic [TSW-1:0] et;
    v  = (q.size() != 0);
    ed = v ? q[0].d : m_last_d;
    et = TS_EN ? (v ? q[0].t : m_last_t) : '0;
    chk("valid",    64'(chg_valid), 64'(v));
    chk("count",    64'(count),     64'(q.size()));
    chk("data",     64'(chg_data),  64'(ed));
    chk("time",     64'(chg_time),  64'(et));
    chk("overflow", 64'(overflow),  64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  logic [63:0] r64;

  initial begin
    rst = 1'b1; tie = '0; ready = 1'b0; ovfclr = 1'b0;
    rst4 = 1'b1; tie4 = '0; ready4 = 1'b0; ovfclr4 = 1'b0;

    // timestamp wrap on the 4-bit instance
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    tie4 = 8'hA5;                // captured at counter 15
    @(posedge clk); #1;
    chk("w4_valid", 64'(valid4), 64'(1));
    chk("w4_data",  64'(data4),  64'(8'hA5));
    chk("w4_time15", 64'(time4), 64'(TS_EN ? 15 : 0));
    @(posedge clk); #1;
    tie4 = 8'h5A;                // captured at counter 1 after wrap
    @(posedge clk); #1;
    chk("w4_count2", 64'(count4), 64'(2));
    ready4 = 1'b1;
    @(posedge clk); #1;
    chk("w4_data2",  64'(data4), 64'(8'h5A));
    chk("w4_time1",  64'(time4), 64'(TS_EN ? 1 : 0));
    @(posedge clk); #1;
    chk("w4_empty",  64'(valid4), 64'(0));
    chk("w4_lastd",  64'(data4),  64'(8'h5A));
    chk("w4_lastt",  64'(time4),  64'(TS_EN ? 1 : 0));
    ready4 = 1'b0;

    // main instance: reset state
    step();
    step();
    rst = 1'b0;

    // idle with zero word: nothing queued
    repeat (10) step();
    chk("idle_valid", 64'(chg_valid), 64'(0));
    chk("idle_count", 64'(count),     64'(0));

    // first change at cycle 10
    tie = 50'h3_FFFF_0000_1234;
    step();
    chk("first_valid", 64'(chg_valid), 64'(1));
    chk("first_data",  64'(chg_data),  64'(50'h3_FFFF_0000_1234));
    chk("first_time",  64'(chg_time),  64'(TS_EN ? 10 : 0));

    // eight more changes: 8 stored, 9th dropped
    for (int i = 1; i <= 8; i++) begin
      tie = 50'h1000 + 50'(i);
      step();
    end
    chk("full_count", 64'(count),    64'(8));
    chk("full_ovf",   64'(overflow), 64'(1));
    ovfclr = 1'b1;
    step();
    ovfclr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'(0));

    // full + change + pop in the same cycle
    tie   = 50'h2_AAAA_5555_0F0F;
    ready = 1'b1;
    step();
    chk("fp_count", 64'(count),    64'(8));
    chk("fp_ovf",   64'(overflow), 64'(0));
    repeat (8) step();
    chk("fp_tail",  64'(chg_data),  64'(50'h2_AAAA_5555_0F0F));
    chk("fp_empty", 64'(chg_valid), 64'(0));
    ready = 1'b0;

    // OvfClr wins over a same-cycle overflow
    for (int i = 0; i < 8; i++) begin
      tie = 50'h5000 + 50'(i);
      step();
    end
    tie    = 50'h6000;
    ovfclr = 1'b1;
    step();
    ovfclr = 1'b0;
    chk("clr_prio", 64'(overflow), 64'(0));
    ready = 1'b1;
    repeat (8) step();
    ready = 1'b0;

    // reset mid-operation with 5 entries
    for (int i = 0; i < 5; i++) begin
      tie = 50'h7000 + 50'(i);
      step();
    end
    chk("pre_rst_count", 64'(count), 64'(5));
    rst = 1'b1;
    tie = 50'h7777;
    step();
    chk("rst_count", 64'(count),     64'(0));
    chk("rst_valid", 64'(chg_valid), 64'(0));
    tie = 50'h1234;
    step();
    tie = '0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", 64'(count), 64'(0));

    // random traffic: slow consumer, then fast consumer
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        r64 = {$urandom(), $urandom()};
        tie = r64[W-1:0];
      end
      ready  = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovfclr = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
